// File: rtl/ser_frame_gen_if.sv
// Load handshake, parity config, advance strobe and serial status for ser_frame_gen.
interface ser_frame_gen_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] P_DATA;
    logic              DATA_VLD;
    logic              DATA_RDY;
    logic              PAR_EN;
    logic              PAR_TYP;
    logic              SER_EN;
    logic              SER_DATA;
    logic              SER_BUSY;
    logic              SER_DONE;

    // Producer / framing side: supplies payloads and the advance strobe.
    modport master (
        output P_DATA, DATA_VLD, PAR_EN, PAR_TYP, SER_EN,
        input  DATA_RDY, SER_DATA, SER_BUSY, SER_DONE
    );

    // Serializer side.
    modport slave (
        input  P_DATA, DATA_VLD, PAR_EN, PAR_TYP, SER_EN,
        output DATA_RDY, SER_DATA, SER_BUSY, SER_DONE
    );
endinterface

// File: rtl/ser_frame_gen.sv
// Parallel-to-serial engine: configurable bit order, optional parity, ready/valid load.
module ser_frame_gen #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter bit          IDLE_VAL  = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    ser_frame_gen_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              ser_q, ser_d;
    logic              busy_q, busy_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              rel_c;

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            ser_q     <= IDLE_VAL;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and next-output logic; every register holds unless a strobe or accept moves it.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        ser_d     = ser_q;
        busy_d    = busy_q;
        rdy_d     = rdy_q;
        done_d    = 1'b0;
        rel_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Accept wins over SER_EN; the first bit waits for a later strobe.
                if (bus.DATA_VLD) begin
                    shreg_d   = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
                    cnt_d     = CNT_W'(DATA_W);
                    state_d   = SHIFT;
                    busy_d    = 1'b1;
                    rdy_d     = 1'b0;
                end
            end
            SHIFT: begin
                if (bus.SER_EN) begin
                    if (cnt_q != '0) begin
                        if (LSB_FIRST) begin
                            ser_d   = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end else begin
                            ser_d   = shreg_q[DATA_W-1];
                            shreg_d = shreg_q << 1;
                        end
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (par_en_q) begin
                        ser_d   = par_bit_q;
                        state_d = PARITY;
                    end else begin
                        rel_c = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bus.SER_EN) begin
                    rel_c = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Release edge: line back to idle, ready again in the same cycle as the done pulse.
        if (rel_c) begin
            ser_d   = IDLE_VAL;
            state_d = IDLE;
            busy_d  = 1'b0;
            rdy_d   = 1'b1;
            done_d  = 1'b1;
        end
    end

    assign bus.SER_DATA = ser_q;
    assign bus.SER_BUSY = busy_q;
    assign bus.DATA_RDY = rdy_q;
    assign bus.SER_DONE = done_q;
endmodule

// File: tb/tb_ser_frame_gen.sv
// Scoreboard bench: three serializer variants driven by one shared stimulus stream.
module tb_ser_frame_gen;
    logic CLK;
    logic RST;

    logic [7:0] pdata;
    logic       vld, pe, pt, ser_en;
    logic       rdy [3];
    logic       busy[3];
    logic       sdat[3];
    logic       done[3];

    ser_frame_gen_if #(.DATA_W(8)) if0 ();
    ser_frame_gen_if #(.DATA_W(8)) if1 ();
    ser_frame_gen_if #(.DATA_W(5)) if2 ();

    assign if0.P_DATA = pdata;      assign if1.P_DATA = pdata;      assign if2.P_DATA = pdata[4:0];
    assign if0.DATA_VLD = vld;      assign if1.DATA_VLD = vld;      assign if2.DATA_VLD = vld;
    assign if0.PAR_EN = pe;         assign if1.PAR_EN = pe;         assign if2.PAR_EN = pe;
    assign if0.PAR_TYP = pt;        assign if1.PAR_TYP = pt;        assign if2.PAR_TYP = pt;
    assign if0.SER_EN = ser_en;     assign if1.SER_EN = ser_en;     assign if2.SER_EN = ser_en;

    assign rdy[0] = if0.DATA_RDY;   assign rdy[1] = if1.DATA_RDY;   assign rdy[2] = if2.DATA_RDY;
    assign busy[0] = if0.SER_BUSY;  assign busy[1] = if1.SER_BUSY;  assign busy[2] = if2.SER_BUSY;
    assign sdat[0] = if0.SER_DATA;  assign sdat[1] = if1.SER_DATA;  assign sdat[2] = if2.SER_DATA;
    assign done[0] = if0.SER_DONE;  assign done[1] = if1.SER_DONE;  assign done[2] = if2.SER_DONE;

    ser_frame_gen #(.DATA_W(8), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u0 (.CLK(CLK), .RST(RST), .bus(if0));
    ser_frame_gen #(.DATA_W(8), .LSB_FIRST(1'b0), .IDLE_VAL(1'b1)) u1 (.CLK(CLK), .RST(RST), .bus(if1));
    ser_frame_gen #(.DATA_W(5), .LSB_FIRST(1'b1), .IDLE_VAL(1'b1)) u2 (.CLK(CLK), .RST(RST), .bus(if2));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int wid(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic bit lsb(input int k);
        return (k != 1);
    endfunction

    // Expected on-wire sequence (data bits in send order, then parity if enabled).
    function automatic void build(input logic [7:0] d, input int w, input bit lf, input bit en,
                                  input bit typ, output logic [17:0] bits, output int len);
        bit p;
        p    = typ;
        bits = '0;
        len  = 0;
        for (int i = 0; i < w; i++) begin
            bits[len] = lf ? d[i] : d[w-1-i];
            p         = p ^ d[i];
            len++;
        end
        if (en) begin
            bits[len] = p;
            len++;
        end
    endfunction

    typedef struct {
        int          dut;
        logic [17:0] bits;
        int          len;
    } frame_t;

    frame_t      exp_q[$];
    bit          m_busy[3];
    bit          m_line[3];
    bit          m_done[3];
    logic [17:0] m_bits[3];
    int          m_len [3];
    int          m_pos [3];
    int          acc_cnt = 0;

    // Reference model: a frame is a list of line levels consumed one per strobe, ending at idle.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < 3; k++) begin
                m_busy[k] = 1'b0;
                m_line[k] = 1'b1;
                m_done[k] = 1'b0;
                m_pos[k]  = 0;
            end
            exp_q.delete();
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_done[k] = 1'b0;
                if (!m_busy[k]) begin
                    if (vld) begin
                        frame_t f;
                        build(pdata, wid(k), lsb(k), pe, pt, m_bits[k], m_len[k]);
                        f.dut  = k;
                        f.bits = m_bits[k];
                        f.len  = m_len[k];
                        exp_q.push_back(f);
                        m_busy[k] = 1'b1;
                        m_pos[k]  = 0;
                        acc_cnt++;
                    end
                end else if (ser_en) begin
                    if (m_pos[k] < m_len[k]) begin
                        m_line[k] = m_bits[k][m_pos[k]];
                        m_pos[k]++;
                    end else begin
                        m_line[k] = 1'b1;
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                    end
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int tmo    = 0;
    bit fin_req = 1'b0;
    bit fin_ack = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t act=%0h exp=%0h", nm, k, $time, act, exp);
        end
    endtask

    logic [17:0] c_bits[3];
    int          c_len [3];
    bit          busy_prev[3];
    bit          en_prev = 1'b0;
    int          idx_m;

    // Monitor: per-cycle status vs model, and whole frames collected from the line vs the scoreboard.
    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            chk("rdy",  k, 32'(rdy[k]),  32'(!m_busy[k]));
            chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
            chk("line", k, 32'(sdat[k]), 32'(m_line[k]));
            chk("done", k, 32'(done[k]), 32'(m_done[k]));
            if (!RST) begin
                c_len[k]     = 0;
                c_bits[k]    = '0;
                busy_prev[k] = 1'b0;
            end else begin
                if (en_prev && busy_prev[k] && done[k]) begin
                    idx_m = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (exp_q[i].dut == k) begin
                            idx_m = i;
                            break;
                        end
                    end
                    if (idx_m < 0) begin
                        chk("frame_expected", k, 32'd0, 32'd1);
                    end else begin
                        chk("frame_len",  k, 32'(c_len[k]),  32'(exp_q[idx_m].len));
                        chk("frame_bits", k, 32'(c_bits[k]), 32'(exp_q[idx_m].bits));
                        exp_q.delete(idx_m);
                    end
                    c_len[k]  = 0;
                    c_bits[k] = '0;
                end else if (en_prev && busy_prev[k] && c_len[k] < 18) begin
                    c_bits[k][c_len[k]] = sdat[k];
                    c_len[k]++;
                end
                busy_prev[k] = busy[k];
            end
        end
        en_prev = ser_en;
        if (fin_req && !fin_ack) begin
            chk("queue_empty", -1, 32'(exp_q.size()), 32'd0);
            chk("timeouts",    -1, 32'(tmo),          32'd0);
            fin_ack = 1'b1;
        end
    end

    // SER_EN pattern: 0 = random, N = one strobe every N cycles.
    int en_period = 1;
    int cyc = 0;
    initial begin
        ser_en = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (en_period == 0) ser_en = 1'($urandom_range(0, 1));
            else                ser_en = ((cyc % en_period) == 0);
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 3000 && (m_busy[0] || m_busy[1] || m_busy[2]); i++) begin
            @(posedge CLK);
            #1;
        end
        if (m_busy[0] || m_busy[1] || m_busy[2]) tmo++;
    endtask

    task automatic send(input logic [7:0] d, input bit en, input bit typ);
        wait_idle();
        @(posedge CLK);
        #1;
        pdata = d;
        pe    = en;
        pt    = typ;
        vld   = 1'b1;
        @(posedge CLK);
        #1;
        vld   = 1'b0;
    endtask

    int base;
    initial begin
        RST   = 1'b0;
        vld   = 1'b0;
        pdata = '0;
        pe    = 1'b0;
        pt    = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;

        en_period = 1;
        send(8'hC4, 1'b0, 1'b0);
        send(8'hC4, 1'b1, 1'b0);
        send(8'hC4, 1'b1, 1'b1);

        en_period = 4;
        send(8'hA5, 1'b0, 1'b0);

        // Payload offered during a frame must wait for the release cycle.
        en_period = 1;
        wait_idle();
        @(posedge CLK);
        #1;
        base  = acc_cnt;
        pdata = 8'h00;
        pe    = 1'b0;
        pt    = 1'b0;
        vld   = 1'b1;
        @(posedge CLK);
        #1;
        pdata = 8'hFF;
        for (int i = 0; i < 200 && acc_cnt < base + 6; i++) begin
            @(posedge CLK);
            #1;
        end
        if (acc_cnt < base + 6) tmo++;
        vld = 1'b0;

        // Abort mid-frame, then a clean frame after release.
        send(8'h3C, 1'b1, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        send(8'h5A, 1'b0, 1'b0);

        send(8'h16, 1'b1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       en_period = 1;
                1:       en_period = 2;
                2:       en_period = 3;
                default: en_period = 0;
            endcase
            send(8'($urandom), 1'($urandom), 1'($urandom));
        end

        wait_idle();
        repeat (2) @(posedge CLK);
        fin_req = 1'b1;
        for (int i = 0; i < 10 && !fin_ack; i++) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ser_frame_gen.md
Name: ser_frame_gen

Overview:
Parametrised parallel-to-serial engine for the UART transmit path. It is the next generation of the basic serializer and adds the following:
- configurable bit order
- optional even/odd parity insertion
- a ready/valid load handshake
- explicit busy/done status

The bit rate is set by the SER_EN strobe, normally the baud tick, so each output bit is held from one SER_EN to the next. The framing FSM (start/stop bits) drives this block.

Parameters:
DATA_W, 8, payload width in bits; legal range 2..16.
LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit DATA_W-1 is sent first.
IDLE_VAL, 1, level driven on SER_DATA when no bit is being presented.

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous active-low reset.
P_DATA  in  DATA_W  parallel payload.
DATA_VLD  in  1  payload valid.
DATA_RDY  out  1  block can accept a payload; high exactly in IDLE.
PAR_EN  in  1  insert parity bit after the payload; sampled at accept.
PAR_TYP  in  1  0 = even parity, 1 = odd parity; sampled at accept.
SER_EN  in  1  advance strobe, one bit per asserted cycle.
SER_DATA  out  1  serial output, registered.
SER_BUSY  out  1  high whenever the state is not IDLE.
SER_DONE  out  1  one-cycle pulse when the frame is released.

Behaviour:
- Reset (RST=0, asynchronous) sets:
  - state = IDLE
  - SER_DATA = IDLE_VAL
  - SER_DONE = 0, SER_BUSY = 0, DATA_RDY = 1
  - shift register = 0, bit counter = 0, latched parity config = 0
- Reset mid-frame aborts the frame immediately. No SER_DONE is generated.
- States: IDLE, SHIFT, PARITY.
- Accept: on a rising edge with DATA_VLD=1 and state IDLE:
  - P_DATA is latched into the shift register.
  - PAR_EN and PAR_TYP are latched.
  - Parity bit is computed as (XOR reduce of P_DATA) XOR PAR_TYP.
  - Counter loads DATA_W and the next state is SHIFT.
  - SER_DATA remains IDLE_VAL.
- DATA_VLD is ignored when DATA_RDY=0. There is no queuing, and the captured payload is not altered.
- SHIFT: each edge with SER_EN=1 and counter>0:
  - SER_DATA takes the next payload bit. When LSB_FIRST=1 the register shifts right and bit 0 is used; when LSB_FIRST=0 it shifts left and bit DATA_W-1 is used.
  - Counter decrements.
- SHIFT, edge with SER_EN=1 and counter=0 (the last data bit has been presented):
  - If parity was latched enabled: SER_DATA = parity bit, next state PARITY.
  - Otherwise this is the release edge (see below).
- PARITY, edge with SER_EN=1: release edge.
- Release edge:
  - SER_DATA = IDLE_VAL, state = IDLE.
  - SER_DONE = 1 for exactly the following cycle.
  - DATA_RDY = 1 in that same cycle, so back-to-back accepts are possible.
- If SER_EN=0 in SHIFT or PARITY, all state and SER_DATA hold, with no timeout.
- SER_EN in IDLE has no effect.
- If SER_EN and DATA_VLD are both high in IDLE, only the accept happens; the first bit needs a later SER_EN.
- Frame length, counted in SER_EN strobes after accept: DATA_W presenting strobes, plus 1 for parity if enabled, plus 1 release strobe.
- Counter width is clog2(DATA_W+1). Counter arithmetic never wraps: decrement happens only while counter>0.
- SER_BUSY is 1 from the edge after accept until the release edge, inclusive of the PARITY state.

Test Plan:
1. DATA_W=8, LSB_FIRST=1, P_DATA=8'hC4, PAR_EN=0, SER_EN held high from the cycle after accept.
   -> SER_DATA = 0,0,1,0,0,0,1,1 on edges 1..8. Edge 9: SER_DATA=1, SER_DONE pulses once, DATA_RDY=1.
2. LSB_FIRST=0, P_DATA=8'hC4, PAR_EN=1: run once with PAR_TYP=0 and once with PAR_TYP=1.
   -> Data bits 1,1,0,0,0,1,0,0. Parity bit = 1 (even) or 0 (odd) on edge 9. SER_DONE follows edge 10.
3. SER_EN asserted every 4th cycle (1 of 4) during an 8'hA5 frame.
   -> Each bit is held exactly 4 cycles. Sequence 1,0,1,0,0,1,0,1. SER_BUSY stays high for 36 cycles.
4. DATA_VLD=1 with P_DATA=8'hFF during an 8'h00 frame.
   -> DATA_RDY=0 and the transmitted bits stay all 0. In the SER_DONE cycle DATA_VLD is accepted, and the next frame sends 8'hFF.
5. RST pulled low after bit 3 of a frame.
   -> Asynchronously: SER_DATA=1, SER_BUSY=0, DATA_RDY=1, no SER_DONE. After reset is released, a new 8'h5A frame transmits correctly.
6. DATA_W=5, LSB_FIRST=1, P_DATA=5'b10110, PAR_EN=1, PAR_TYP=1.
   -> SER_DATA = 0,1,1,0,1 then parity 0. SER_DONE one cycle later.
